// File: rtl/light_seq_ctrl.sv
// Traffic-light phase sequencer: drives the downstream phase counter (init/cnt_en),
// the lamps, the pedestrian walk lamp, and a sticky watchdog fault with amber flash.
module light_seq_ctrl #(
  parameter int pINIT_WIDTH = 3,
  parameter int pWDOG_MAX   = 63,
  parameter int pWDOG_WIDTH = 6,
  parameter int pFLASH_HALF = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   last,
  input  logic                   ped_req,
  output logic [pINIT_WIDTH-1:0] init,
  output logic                   cnt_en,
  output logic [pINIT_WIDTH-1:0] light,
  output logic                   walk,
  output logic                   fault
);

  localparam int FLW = (pFLASH_HALF > 1) ? $clog2(pFLASH_HALF) : 1;
  localparam logic [pINIT_WIDTH-1:0] RED_C = pINIT_WIDTH'(3'b100);
  localparam logic [pINIT_WIDTH-1:0] YEL_C = pINIT_WIDTH'(3'b010);
  localparam logic [pINIT_WIDTH-1:0] GRN_C = pINIT_WIDTH'(3'b001);
  localparam logic [pWDOG_WIDTH-1:0] WDOG_MAX_C = pWDOG_WIDTH'(pWDOG_MAX);
  localparam logic [FLW-1:0] FLASH_LAST_C = FLW'(pFLASH_HALF - 1);

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_RED    = 3'd1,
    S_GREEN  = 3'd2,
    S_YELLOW = 3'd3,
    S_FLASH  = 3'd4
  } state_e;

  state_e                  state_q, state_d, nxt_s;
  logic                    entry_q, entry_d, adv_s;
  logic [pWDOG_WIDTH-1:0]  wdog_q, wdog_d;
  logic                    pend_q, pend_d;
  logic [FLW-1:0]          flash_cnt_q, flash_cnt_d;
  logic [pINIT_WIDTH-1:0]  init_q, init_d, light_q, light_d;
  logic                    cnt_en_q, cnt_en_d, walk_q, walk_d, fault_q, fault_d;

  function automatic logic [pINIT_WIDTH-1:0] phase_code(input state_e s);
    case (s)
      S_RED:    phase_code = RED_C;
      S_GREEN:  phase_code = GRN_C;
      S_YELLOW: phase_code = YEL_C;
      default:  phase_code = RED_C;
    endcase
  endfunction

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    entry_d     = 1'b0;
    wdog_d      = wdog_q;
    pend_d      = pend_q | ped_req;
    flash_cnt_d = flash_cnt_q;
    init_d      = '0;
    light_d     = light_q;
    cnt_en_d    = 1'b0;
    walk_d      = walk_q;
    fault_d     = fault_q;
    adv_s       = 1'b0;
    nxt_s       = S_RED;

    case (state_q)
      S_START: begin
        light_d = RED_C;
        walk_d  = 1'b0;
        if (en) begin
          adv_s = 1'b1;
          nxt_s = S_RED;
        end else begin
          adv_s = 1'b0;
        end
      end
      S_RED, S_GREEN, S_YELLOW: begin
        if (!en) begin
          cnt_en_d = 1'b0;
        end else if (last && !entry_q) begin
          // last is only trusted once the counter has finished loading
          adv_s = 1'b1;
          case (state_q)
            S_RED:    nxt_s = S_GREEN;
            S_GREEN:  nxt_s = S_YELLOW;
            default:  nxt_s = S_RED;
          endcase
        end else if (wdog_q == WDOG_MAX_C) begin
          state_d     = S_FLASH;
          fault_d     = 1'b1;
          light_d     = YEL_C;
          walk_d      = 1'b0;
          flash_cnt_d = '0;
        end else begin
          cnt_en_d = 1'b1;
          if (!last) begin
            wdog_d = wdog_q + pWDOG_WIDTH'(1);
          end else begin
            wdog_d = wdog_q;
          end
        end
      end
      S_FLASH: begin
        walk_d = 1'b0;
        if (flash_cnt_q == FLASH_LAST_C) begin
          flash_cnt_d = '0;
          light_d     = (light_q == YEL_C) ? '0 : YEL_C;
        end else begin
          flash_cnt_d = flash_cnt_q + FLW'(1);
        end
      end
      default: begin
        state_d = S_START;
        light_d = RED_C;
      end
    endcase

    if (adv_s) begin
      state_d  = nxt_s;
      entry_d  = 1'b1;
      wdog_d   = '0;
      cnt_en_d = 1'b1;
      init_d   = phase_code(nxt_s);
      light_d  = phase_code(nxt_s);
      if (nxt_s == S_RED) begin
        walk_d = pend_q | ped_req;
        pend_d = 1'b0;
      end else begin
        walk_d = 1'b0;
      end
    end else begin
      entry_d = entry_d;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_START;
      entry_q     <= 1'b0;
      wdog_q      <= '0;
      pend_q      <= 1'b0;
      flash_cnt_q <= '0;
      init_q      <= '0;
      light_q     <= RED_C;
      cnt_en_q    <= 1'b0;
      walk_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      wdog_q      <= wdog_d;
      pend_q      <= pend_d;
      flash_cnt_q <= flash_cnt_d;
      init_q      <= init_d;
      light_q     <= light_d;
      cnt_en_q    <= cnt_en_d;
      walk_q      <= walk_d;
      fault_q     <= fault_d;
    end
  end

  assign init   = init_q;
  assign light  = light_q;
  assign cnt_en = cnt_en_q;
  assign walk   = walk_q;
  assign fault  = fault_q;

endmodule
